// File: rtl/bcd2_seg_scan_if.sv
// Display-side bundle for the two-digit scan driver: BCD in and scan enable
// from the counter side, segment bus, digit enables and status back out.
interface bcd2_seg_scan_if;
  logic       en;
  logic [7:0] bcd_in;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;
  logic       bcd_err;

  modport master (
    output en,
    output bcd_in,
    input  seg,
    input  an,
    input  frame_tick,
    input  bcd_err
  );

  modport slave (
    input  en,
    input  bcd_in,
    output seg,
    output an,
    output frame_tick,
    output bcd_err
  );
endinterface

// File: rtl/bcd2_seg_scan.sv
// Two-digit multiplexed 7-segment scanner: snapshots packed BCD once per frame,
// lights low then high digit with optional blanking gaps and leading-zero blanking.
module bcd2_seg_scan #(
  parameter int DIV_CYC        = 50000,
  parameter int BLANK_CYC      = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int LZB            = 1
) (
  input  logic            clk,
  input  logic            reset,
  bcd2_seg_scan_if.slave  bus
);

  localparam int MAX_CYC = (DIV_CYC > BLANK_CYC) ? DIV_CYC : BLANK_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);

  localparam logic       HAS_GAP = (BLANK_CYC != 0);
  localparam logic       LZB_ON  = (LZB != 0);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHOW_LO = 3'd1,
    GAP_LO  = 3'd2,
    SHOW_HI = 3'd3,
    GAP_HI  = 3'd4
  } state_t;

  // Active-high gfedcba glyph; anything above 9 shows a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] glyph;
    case (digit)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h40;
    endcase
    return glyph;
  endfunction

  function automatic logic [6:0] seg_drive(input logic [6:0] glyph);
    return (SEG_ACTIVE_LOW != 0) ? ~glyph : glyph;
  endfunction

  function automatic logic [1:0] an_drive(input logic [1:0] lit_mask);
    return (AN_ACTIVE_LOW != 0) ? ~lit_mask : lit_mask;
  endfunction

  function automatic logic bcd_bad(input logic [7:0] packed_bcd);
    return (packed_bcd[7:4] > 4'd9) || (packed_bcd[3:0] > 4'd9);
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       snap_r;
  logic [6:0]       seg_r;
  logic [1:0]       an_r;
  logic             frame_tick_r;
  logic             bcd_err_r;

  state_t           next_state_s;
  logic [CNT_W-1:0] next_cnt_s;
  logic             enter_lo_s;
  logic [7:0]       next_snap_s;
  logic [6:0]       next_seg_s;
  logic [1:0]       next_an_s;
  logic             next_err_s;

  // Slot sequencing: advance only while enabled; a slot ends on its last count.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    if (bus.en) begin
      case (state_r)
        IDLE: begin
          next_state_s = SHOW_LO;
          next_cnt_s   = CNT_ZERO;
        end
        SHOW_LO: begin
          if (cnt_r == DIV_LAST) begin
            next_state_s = HAS_GAP ? GAP_LO : SHOW_HI;
            next_cnt_s   = CNT_ZERO;
          end else begin
            next_cnt_s = cnt_r + CNT_ONE;
          end
        end
        GAP_LO: begin
          if (cnt_r == BLANK_LAST) begin
            next_state_s = SHOW_HI;
            next_cnt_s   = CNT_ZERO;
          end else begin
            next_cnt_s = cnt_r + CNT_ONE;
          end
        end
        SHOW_HI: begin
          if (cnt_r == DIV_LAST) begin
            next_state_s = HAS_GAP ? GAP_HI : SHOW_LO;
            next_cnt_s   = CNT_ZERO;
          end else begin
            next_cnt_s = cnt_r + CNT_ONE;
          end
        end
        GAP_HI: begin
          if (cnt_r == BLANK_LAST) begin
            next_state_s = SHOW_LO;
            next_cnt_s   = CNT_ZERO;
          end else begin
            next_cnt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          next_state_s = IDLE;
          next_cnt_s   = CNT_ZERO;
        end
      endcase
    end else begin
      next_state_s = state_r;
      next_cnt_s   = cnt_r;
    end
  end

  // Output values for the slot being entered, so outputs track state with no lag.
  always_comb begin
    enter_lo_s  = bus.en && (next_state_s == SHOW_LO) && (state_r != SHOW_LO);
    next_snap_s = enter_lo_s ? bus.bcd_in : snap_r;
    next_err_s  = enter_lo_s ? bcd_bad(bus.bcd_in) : bcd_err_r;
    next_seg_s  = SEG_OFF;
    next_an_s   = AN_OFF;
    if (bus.en) begin
      case (next_state_s)
        SHOW_LO: begin
          next_seg_s = seg_drive(seg_decode(next_snap_s[3:0]));
          next_an_s  = an_drive(2'b01);
        end
        SHOW_HI: begin
          // A blanked leading zero keeps its slot time, just unlit.
          if (LZB_ON && (next_snap_s[7:4] == 4'h0)) begin
            next_seg_s = SEG_OFF;
            next_an_s  = AN_OFF;
          end else begin
            next_seg_s = seg_drive(seg_decode(next_snap_s[7:4]));
            next_an_s  = an_drive(2'b10);
          end
        end
        default: begin
          next_seg_s = SEG_OFF;
          next_an_s  = AN_OFF;
        end
      endcase
    end else begin
      next_seg_s = SEG_OFF;
      next_an_s  = AN_OFF;
    end
  end

  // Scan state, snapshot and registered display outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      snap_r       <= 8'h00;
      seg_r        <= SEG_OFF;
      an_r         <= AN_OFF;
      frame_tick_r <= 1'b0;
      bcd_err_r    <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      cnt_r        <= next_cnt_s;
      snap_r       <= next_snap_s;
      seg_r        <= next_seg_s;
      an_r         <= next_an_s;
      frame_tick_r <= enter_lo_s;
      bcd_err_r    <= next_err_s;
    end
  end

  assign bus.seg        = seg_r;
  assign bus.an         = an_r;
  assign bus.frame_tick = frame_tick_r;
  assign bus.bcd_err    = bcd_err_r;

endmodule

// File: doc/bcd2_seg_scan.md
Name: bcd2_seg_scan

Overview:
- Two-digit multiplexed 7-segment display driver. Sits directly downstream of the 2-digit BCD counter (00–99).
- Consumes the packed BCD byte (high digit [7:4], low digit [3:0]) and drives one shared segment bus plus two digit enables.
- Snapshots the input once per scan frame, so a count change mid-frame never tears the display.
- Inserts blanking gaps between digits to suppress ghosting. Supports optional leading-zero blanking and flags invalid BCD.

Parameters:
- DIV_CYC, 50000, clk cycles each digit is lit per slot (≥1).
- BLANK_CYC, 500, clk cycles of all-off gap after each digit slot (0 = no gap).
- SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low (common-anode); 0 = active-high.
- AN_ACTIVE_LOW, 1, 1 = digit enables active-low; 0 = active-high.
- LZB, 1, 1 = blank high digit when it is 0.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  reset reset, asynchronous, active-high.
- en  input  1  scan enable; 0 freezes the scan and blanks the display.
- bcd_in  input  8  packed BCD from the upstream counter (updates on falling clk edge, so it is stable at the rising edge).
- seg  output  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- an  output  2  digit enables; an[0] = low digit, an[1] = high digit, polarity per AN_ACTIVE_LOW.
- frame_tick  output  1  one-cycle pulse when a new snapshot is taken.
- bcd_err  output  1  high for the whole frame if the snapshot holds a nibble >9.

Behaviour:

Reset (asynchronous):
- seg = all off, an = all off (polarity-correct).
- frame_tick = 0, bcd_err = 0, snapshot = 8'h00.
- state = IDLE, slot counter = 0.

State machine (registered):
- States: IDLE, SHOW_LO, GAP_LO, SHOW_HI, GAP_HI.
- IDLE → SHOW_LO: on the first rising edge with en=1. This edge captures the snapshot.
- SHOW_LO: DIV_CYC cycles, then → GAP_LO.
- GAP_LO: BLANK_CYC cycles, then → SHOW_HI. Skipped when BLANK_CYC=0.
- SHOW_HI: DIV_CYC cycles, then → GAP_HI (or directly → SHOW_LO when BLANK_CYC=0).
- GAP_HI: BLANK_CYC cycles, then → SHOW_LO.

Frame timing:
- Frame length = 2·(DIV_CYC+BLANK_CYC) cycles.
- Every entry into SHOW_LO captures snapshot ← bcd_in, pulses frame_tick for 1 cycle, and updates bcd_err from the new snapshot.
- This includes the entry from IDLE.

Slot counter:
- Width = clog2(max(DIV_CYC, BLANK_CYC)+1).
- Reset to 0 on every state change. A state ends when count = length−1.

Outputs (all registered, zero-cycle offset to state):
- seg/an update on the same edge as the state transition.
- SHOW_LO: an[0] on, seg = decode(snapshot[3:0]).
- SHOW_HI: an[1] on, seg = decode(snapshot[7:4]).
- SHOW_HI with LZB=1 and snapshot[7:4]=0: an all off, seg all off. Timing is unchanged.
- GAP_*: an all off, seg all off.
- Never more than one an asserted in any cycle.

Decode (active-high gfedcba, inverted if SEG_ACTIVE_LOW):
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- A..F → dash 40. bcd_err=1 for that frame.

Enable handling:
- en=0 mid-frame: state and counter hold, seg/an forced off on the next edge.
- en=1: resumes the same state and count with the same snapshot. No frame_tick until the next natural SHOW_LO entry.

Boundaries:
- bcd_in changing mid-frame: ignored until the next frame.
- 99→00 wrap: shown at the next frame.
- Reset asserted mid-slot: outputs off immediately (asynchronous).

Test Plan:
1. DIV_CYC=4, BLANK_CYC=1, active-low, LZB=1; release reset, en=1, bcd_in=8'h47 → frame_tick on edge 1; seg=~6F→ wait, low digit 7: seg=~07=7'h78, an=2'b10 for 4 cycles; then 1 cycle an=11/seg=7F; then seg=~66=7'h19, an=2'b01 for 4 cycles; gap; frame_tick again at cycle 11.
2. Same parameters, bcd_in=8'h05 → high slot fully blank (an=11, seg=7F); low slot seg=~6D=7'h12. Repeat with LZB=0 → high slot seg=~3F=7'h40, an=01.
3. bcd_in changes 12→13 at cycle 3 of SHOW_LO → remainder of frame still shows 12; next frame shows 13.
4. bcd_in=8'h9A → low slot shows dash (seg=~40=7'h3F), bcd_err=1 for the frame; next frame with 8'h99 → bcd_err=0.
5. en dropped for 3 cycles during SHOW_HI count 2 → outputs off; on resume, 2 remaining SHOW_HI cycles, no extra frame_tick. Reset pulse mid-slot → seg/an off before the next clock edge, state IDLE.
6. BLANK_CYC=0, DIV_CYC=1 → an alternates 10/01 every cycle, frame_tick every 2 cycles, never an=00 while en=1.
